adder_selftest: RTL and testbench
=================================

ADDER_SELFTEST -- requirements
Module: adder_selftest

Interface
REQ-001 Parameter SETTLE, default 2: number of wait cycles between driving a vector and sampling the response; legal range 1..15.
REQ-002 Parameter ROUNDS, default 4: number of passes over the full vector set; legal range 1..255.
REQ-003 clk  input  1  single clock; all state SHALL change only on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  one-cycle request to run a test; sampled only in IDLE and DONE.
REQ-006 stim  output  8  stimulus to the DUT dedicated-input pins: stim[0]=a, stim[1]=b, stim[7:2]=0.
REQ-007 resp  input  8  DUT dedicated-output pins: resp[0]=sum, resp[1]=carry, resp[7:2] ignored.
REQ-008 busy  output  1  high from the first DRIVE cycle through the last CHECK cycle.
REQ-009 done  output  1  high while in DONE.
REQ-010 pass  output  1  valid only while done=1; high iff err_cnt==0.
REQ-011 err_cnt  output  8  count of mismatching checks, saturating at 255.

Function
REQ-012 The FSM SHALL have the states IDLE, DRIVE, WAIT, CHECK and DONE, encoded as a registered state variable.
REQ-013 IDLE/DONE with start=1 -> DRIVE: clear err_cnt, vector index idx=0 and round counter=0.
REQ-014 DRIVE (1 cycle): stim[1:0]={b,a}=idx, registered; go to WAIT with wait counter=0.
REQ-015 WAIT: count SETTLE cycles; after exactly SETTLE cycles in WAIT, go to CHECK.
REQ-016 CHECK (1 cycle): sample resp[1:0]; expected value is sum=a^b, carry=a&b; on mismatch err_cnt+=1, held at 255 once reached.
REQ-017 Vector advance after CHECK: if idx<3 then idx+=1 -> DRIVE; if idx==3 then idx wraps to 0 and round+=1.
REQ-018 After the wrap: if round==ROUNDS -> DONE, otherwise -> DRIVE.
REQ-019 Cost per vector SHALL be SETTLE+2 cycles; done SHALL rise exactly 4*ROUNDS*(SETTLE+2) cycles after the cycle start is sampled.
REQ-020 stim SHALL be 8'h00 in IDLE and DONE; stim SHALL hold the current vector unchanged through DRIVE, WAIT and CHECK.
REQ-021 start while busy=1 SHALL be ignored, with no effect on counters or state.
REQ-022 DONE SHALL hold done, pass and err_cnt stable until start or rst.
REQ-023 err_cnt SHALL remain readable (not cleared) in DONE and IDLE until the next start.
REQ-024 resp[7:2] SHALL never affect pass or err_cnt.

Reset
REQ-025 rst=1 at a clock edge forces state=IDLE, stim=0, busy=0, done=0, pass=0, err_cnt=0, idx=0, round=0, and clears the first-fail registers if present.
REQ-026 rst SHALL take priority over start and over any in-progress run; a run aborted by reset SHALL NOT assert done.

Configuration
REQ-027 Macro ADDER_SELFTEST_FAILLOG_EN enables the first-fail log.
REQ-028 With the macro defined: add output fail_vec (2 bits, {b,a}) and output fail_resp (2 bits, {carry,sum}), captured at the first mismatch of a run and held until the next start or rst; both SHALL be 0 if the run has no mismatch.
REQ-029 Without the macro: fail_vec and fail_resp ports and their registers SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Correct DUT model, SETTLE=2, ROUNDS=4, start pulse: done rises exactly 64 cycles later, pass=1, err_cnt=0.
REQ-031 Stuck DUT forcing resp=8'h00: done with err_cnt=12 (3 mismatches per round x 4), pass=0; with the FAILLOG macro, fail_vec=2'b01 and fail_resp=2'b00.
REQ-032 Correct DUT, ROUNDS=255, carry output forced to 1: err_cnt saturates at 255 (raw mismatch count is 765) and pass=0.
REQ-033 rst asserted during WAIT of round 2: the next cycle shows IDLE, stim=0, err_cnt=0 and busy=0, and done never asserts; a following start completes normally.
REQ-034 Second start pulse issued while busy: no change to completion time (still 64 cycles) or to err_cnt.
REQ-035 start asserted in DONE after a failing run: err_cnt clears to 0 at the first DRIVE cycle, and a correct DUT then yields pass=1.

Source files
------------

// File: rtl/adder_selftest.sv
// Built-in self-test sequencer for a 1-bit half adder: drives all four {b,a} vectors ROUNDS times and counts mismatches.
// Define ADDER_SELFTEST_FAILLOG_EN to add the first-fail capture outputs fail_vec_o / fail_resp_o.
//
//   state   | meaning
//   IDLE    | waiting for start, stim forced to 0
//   DRIVE   | current vector presented on stim
//   WAIT    | SETTLE cycles for the adder outputs to settle
//   CHECK   | compare resp against the half-adder truth table
//   DONE    | results held until start or rst
module adder_selftest #(
    parameter int SETTLE = 2,
    parameter int ROUNDS = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    output logic [7:0] stim_o,
    input  logic [7:0] resp_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [7:0] err_cnt_o
`ifdef ADDER_SELFTEST_FAILLOG_EN
    ,
    output logic [1:0] fail_vec_o,
    output logic [1:0] fail_resp_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(SETTLE - 1);
    localparam logic [7:0] ROUNDS_N  = 8'(ROUNDS);

    state_t     state_q, state_d;
    logic [1:0] stim_q, stim_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] round_q, round_d;
    logic [3:0] wait_q, wait_d;
    logic [7:0] err_q, err_d;
    logic [1:0] expect_w;
    logic       mismatch_w;
    logic       resp_unused;

`ifdef ADDER_SELFTEST_FAILLOG_EN
    logic [1:0] fail_vec_q, fail_vec_d;
    logic [1:0] fail_resp_q, fail_resp_d;
`endif

    // Only {carry,sum} take part in the comparison.
    assign resp_unused = ^resp_i[7:2];
    assign expect_w    = {stim_q[1] & stim_q[0], stim_q[1] ^ stim_q[0]};
    assign mismatch_w  = (resp_i[1:0] != expect_w);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            stim_q  <= 2'b00;
            idx_q   <= 2'b00;
            round_q <= 8'd0;
            wait_q  <= 4'd0;
            err_q   <= 8'd0;
`ifdef ADDER_SELFTEST_FAILLOG_EN
            fail_vec_q  <= 2'b00;
            fail_resp_q <= 2'b00;
`endif
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            idx_q   <= idx_d;
            round_q <= round_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
`ifdef ADDER_SELFTEST_FAILLOG_EN
            fail_vec_q  <= fail_vec_d;
            fail_resp_q <= fail_resp_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        idx_d   = idx_q;
        round_d = round_q;
        wait_d  = wait_q;
        err_d   = err_q;
`ifdef ADDER_SELFTEST_FAILLOG_EN
        fail_vec_d  = fail_vec_q;
        fail_resp_d = fail_resp_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_DRIVE;
                    stim_d  = 2'b00;
                    idx_d   = 2'b00;
                    round_d = 8'd0;
                    err_d   = 8'd0;
`ifdef ADDER_SELFTEST_FAILLOG_EN
                    fail_vec_d  = 2'b00;
                    fail_resp_d = 2'b00;
`endif
                end
            end
            S_DRIVE: begin
                state_d = S_WAIT;
                wait_d  = 4'd0;
            end
            S_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_CHECK: begin
                if (mismatch_w) begin
                    if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
`ifdef ADDER_SELFTEST_FAILLOG_EN
                    // err_q is zero only until the first mismatch of the run.
                    if (err_q == 8'd0) begin
                        fail_vec_d  = stim_q;
                        fail_resp_d = resp_i[1:0];
                    end
`endif
                end
                if (idx_q != 2'd3) begin
                    idx_d   = idx_q + 2'd1;
                    stim_d  = idx_q + 2'd1;
                    state_d = S_DRIVE;
                end else begin
                    idx_d   = 2'd0;
                    stim_d  = 2'd0;
                    round_d = round_q + 8'd1;
                    state_d = (round_d == ROUNDS_N) ? S_DONE : S_DRIVE;
                end
            end
            default: begin
                state_d = S_IDLE;
                stim_d  = 2'b00;
            end
        endcase
    end

    assign stim_o    = {6'b000000, stim_q};
    assign busy_o    = (state_q == S_DRIVE) || (state_q == S_WAIT) || (state_q == S_CHECK);
    assign done_o    = (state_q == S_DONE);
    assign pass_o    = done_o && (err_q == 8'd0);
    assign err_cnt_o = err_q;
`ifdef ADDER_SELFTEST_FAILLOG_EN
    assign fail_vec_o  = fail_vec_q;
    assign fail_resp_o = fail_resp_q;
`endif

endmodule

// File: tb/tb_adder_selftest.sv
// Directed bench for adder_selftest: table of runs against a modelled half adder plus reset/restart/saturation sequences.
module tb_adder_selftest;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_a, start_b;
    logic [7:0] stim_a, resp_a, stim_b, resp_b;
    logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [7:0] err_a, err_b;
`ifdef ADDER_SELFTEST_FAILLOG_EN
    logic [1:0] fv_a, fr_a, fv_b, fr_b;
`endif

    int mode;
    int n_vec = 0;
    int n_bad = 0;

    // Adder model under test: 0 good, 1 stuck at 0, 2 carry stuck at 1, 3 sum inverted.
    always_comb begin
        resp_a = {6'b101101, stim_a[1] & stim_a[0], stim_a[1] ^ stim_a[0]};
        case (mode)
            1:       resp_a = 8'h00;
            2:       resp_a = {6'b101101, 1'b1, stim_a[1] ^ stim_a[0]};
            3:       resp_a = {6'b101101, stim_a[1] & stim_a[0], ~(stim_a[1] ^ stim_a[0])};
            default: ;
        endcase
    end
    assign resp_b = {6'b110011, 1'b1, stim_b[1] ^ stim_b[0]};

    adder_selftest #(.SETTLE(2), .ROUNDS(4)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .stim_o(stim_a), .resp_i(resp_a),
        .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .err_cnt_o(err_a)
`ifdef ADDER_SELFTEST_FAILLOG_EN
        , .fail_vec_o(fv_a), .fail_resp_o(fr_a)
`endif
    );

    adder_selftest #(.SETTLE(1), .ROUNDS(255)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .stim_o(stim_b), .resp_i(resp_b),
        .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .err_cnt_o(err_b)
`ifdef ADDER_SELFTEST_FAILLOG_EN
        , .fail_vec_o(fv_b), .fail_resp_o(fr_b)
`endif
    );

    typedef struct {
        int         mode;
        int         restart;
        logic [7:0] err;
        logic       pass;
        logic [1:0] fv;
        logic [1:0] fr;
    } vec_t;

    vec_t tv[7];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulse start; on return the bench sits at the negedge where done was first seen.
    task automatic run_a(input int restart_at, output int lat, output int trace_bad,
                         output logic [7:0] err_first);
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        lat       = -1;
        trace_bad = 0;
        err_first = err_a;
        for (int k = 0; k < 200; k++) begin
            if (done_a) begin
                lat = k;
                break;
            end
            if (!busy_a || stim_a !== {6'b000000, 2'((k / 4) % 4)}) trace_bad++;
            start_a = (k == restart_at);
            @(negedge clk);
        end
        start_a = 1'b0;
    endtask

    initial begin
        int         lat, tbad, dseen;
        logic [7:0] e0;

        tv[0] = '{0, -1, 8'd0,  1'b1, 2'b00, 2'b00};
        tv[1] = '{1, -1, 8'd12, 1'b0, 2'b01, 2'b00};
        tv[2] = '{0, -1, 8'd0,  1'b1, 2'b00, 2'b00};
        tv[3] = '{2, -1, 8'd12, 1'b0, 2'b00, 2'b10};
        tv[4] = '{3, -1, 8'd16, 1'b0, 2'b00, 2'b01};
        tv[5] = '{1, 30, 8'd12, 1'b0, 2'b01, 2'b00};
        tv[6] = '{0, 5,  8'd0,  1'b1, 2'b00, 2'b00};

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; mode = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_flags_a", {busy_a, done_a, pass_a}, 0);
        check("reset_err_a", err_a, 0);
        check("reset_stim_a", stim_a, 0);
        check("reset_flags_b", {busy_b, done_b, pass_b}, 0);
`ifdef ADDER_SELFTEST_FAILLOG_EN
        check("reset_faillog_a", {fv_a, fr_a}, 0);
`endif

        for (int i = 0; i < 7; i++) begin
            mode = tv[i].mode;
            run_a(tv[i].restart, lat, tbad, e0);
            check($sformatf("latency[%0d]", i), lat, 64);
            check($sformatf("err_clear[%0d]", i), e0, 0);
            check($sformatf("trace[%0d]", i), tbad, 0);
            check($sformatf("err_cnt[%0d]", i), err_a, tv[i].err);
            check($sformatf("pass[%0d]", i), pass_a, tv[i].pass);
            check($sformatf("done_idle[%0d]", i), {busy_a, stim_a}, 0);
`ifdef ADDER_SELFTEST_FAILLOG_EN
            check($sformatf("fail_vec[%0d]", i), fv_a, tv[i].fv);
            check($sformatf("fail_resp[%0d]", i), fr_a, tv[i].fr);
`endif
            repeat (3) @(negedge clk);
            check($sformatf("done_hold[%0d]", i), {done_a, pass_a, err_a, stim_a},
                  {1'b1, tv[i].pass, tv[i].err, 8'h00});
        end

        // Abort during WAIT of the second round, then a clean run.
        mode = 1;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        repeat (17) @(negedge clk);
        check("pre_abort_err", err_a, 3);
        check("pre_abort_busy", busy_a, 1);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check("abort_state", {busy_a, done_a, pass_a, stim_a, err_a}, 0);
        dseen = 0;
        for (int k = 0; k < 100; k++) begin
            if (done_a || busy_a) dseen++;
            @(negedge clk);
        end
        check("abort_no_done", dseen, 0);
        mode = 0;
        run_a(-1, lat, tbad, e0);
        check("after_abort_latency", lat, 64);
        check("after_abort_pass", {pass_a, err_a}, {1'b1, 8'd0});

        // Saturation: 765 raw mismatches over 255 rounds of 3-cycle vectors.
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        lat = -1;
        for (int k = 0; k < 4000; k++) begin
            if (done_b) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        check("sat_latency", lat, 3060);
        check("sat_err_cnt", err_b, 255);
        check("sat_pass", pass_b, 0);
`ifdef ADDER_SELFTEST_FAILLOG_EN
        check("sat_faillog", {fv_b, fr_b}, 4'b0010);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
